// File: rtl/mar_ctrl_pkg.sv
// mar_ctrl_pkg: shared types and constants for the MAR load sequencer.
//   state_e     - sequencer FSM states (IDLE, LOAD, ACK)
//   MAR_SEL_W   - width of the MAR nibble select field
//   MAX_NIBBLES - largest address the MAR can hold, in nibbles
//   REQ_IDX_W   - width of a requester index (up to 4 requesters)
//   lowest_nib  - index of the lowest set bit of a nibble mask
package mar_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ACK  = 2'd2
  } state_e;

  localparam int MAR_SEL_W   = 2;
  localparam int MAX_NIBBLES = 4;
  localparam int REQ_IDX_W   = 2;

  // Scanning downward leaves the lowest set index as the final assignment.
  function automatic logic [MAR_SEL_W-1:0] lowest_nib(input logic [MAX_NIBBLES-1:0] m);
    lowest_nib = '0;
    for (int i = MAX_NIBBLES - 1; i >= 0; i--) begin
      if (m[i]) lowest_nib = MAR_SEL_W'(i);
    end
  endfunction

endpackage

// File: rtl/mar_load_sequencer_if.sv
// mar_load_sequencer_if: requester bus plus MAR drive signals.
//   req/addr_in          - requester levels and flattened addresses
//   gnt/done/busy        - completion acknowledge and status
//   mar_d/mar_sel/mar_g* - nibble data, select, strobe and active-low enables
// Modports: master (address-source side), slave (sequencer side).
interface mar_load_sequencer_if
  import mar_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int NIBBLES = 4,
  parameter int NIB_W   = 4
);
  logic [NUM_REQ-1:0]               req;
  logic [NUM_REQ*NIBBLES*NIB_W-1:0] addr_in;
  logic [NUM_REQ-1:0]               gnt;
  logic                             done;
  logic                             busy;
  logic [NIB_W-1:0]                 mar_d;
  logic [MAR_SEL_W-1:0]             mar_sel;
  logic                             mar_g;
  logic                             mar_g1;
  logic                             mar_g2;

  modport master (
    output req, addr_in,
    input  gnt, done, busy, mar_d, mar_sel, mar_g, mar_g1, mar_g2
  );

  modport slave (
    input  req, addr_in,
    output gnt, done, busy, mar_d, mar_sel, mar_g, mar_g1, mar_g2
  );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   req     - request vector, bit i = requester i
//   ptr     - index of the highest-priority requester this round
//   win_oh  - one-hot winner (zero when no request)
//   win_idx - winner index (zero when no request)
module rr_arbiter
  import mar_ctrl_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]         req,
  input  logic [REQ_IDX_W-1:0] ptr,
  output logic [N-1:0]         win_oh,
  output logic [REQ_IDX_W-1:0] win_idx
);
  int   cand;
  logic found;

  // Walk upward from ptr with wrap; the first requester found wins.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
    cand    = 0;
    for (int off = 0; off < N; off++) begin
      cand = (int'(ptr) + off) % N;
      if (!found && req[cand]) begin
        found        = 1'b1;
        win_oh[cand] = 1'b1;
        win_idx      = REQ_IDX_W'(cand);
      end
    end
  end
endmodule

// File: rtl/mar_load_sequencer.sv
// mar_load_sequencer: shares a nibble-loaded MAR between NUM_REQ requesters.
// Round-robin picks a requester, latches its full address, writes it into
// the MAR one nibble per clock, then pulses gnt/done to that requester.
//   clk, rst - clock and asynchronous active-high reset
//   bus      - mar_load_sequencer_if.slave (requests, acknowledge, MAR drive)
// Optional build macro MAR_SKIP_UNCHANGED_EN: keep a mirror of the MAR and
// only strobe nibbles that differ from it; an unchanged address acks at once.
module mar_load_sequencer
  import mar_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int NIBBLES = 4,
  parameter int NIB_W   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  mar_load_sequencer_if.slave         bus
);
  localparam int ADDR_W = NIBBLES * NIB_W;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic [NIB_W-1:0]     mar_d_q, mar_d_d;
  logic                 mar_g_q, mar_g_d;
  logic                 mar_g1_q, mar_g1_d;
  logic                 mar_g2_q, mar_g2_d;
  logic [REQ_IDX_W-1:0] ptr_q, ptr_d;
  logic [REQ_IDX_W-1:0] win_q, win_d;
  logic [MAR_SEL_W-1:0] nib_cnt_q, nib_cnt_d;
  logic [ADDR_W-1:0]    shadow_q, shadow_d;
  logic [NIBBLES-1:0]   pend_q, pend_d;     // nibbles still to be strobed

  logic [NUM_REQ-1:0]   arb_oh;
  logic [REQ_IDX_W-1:0] arb_idx;
  logic [ADDR_W-1:0]    win_addr;
  logic [ADDR_W-1:0]    src;
  logic [NIBBLES-1:0]   mask;
  logic                 do_strobe;
  logic [MAR_SEL_W-1:0] sidx;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req     (bus.req),
    .ptr     (ptr_q),
    .win_oh  (arb_oh),
    .win_idx (arb_idx)
  );

  assign win_addr = bus.addr_in[int'(arb_idx)*ADDR_W +: ADDR_W];

`ifdef MAR_SKIP_UNCHANGED_EN
  logic [ADDR_W-1:0]  mirror_q, mirror_d;
  logic               mirror_valid_q, mirror_valid_d;
  logic [NIBBLES-1:0] diff;

  // Until the first load completes the MAR contents are unknown.
  always_comb begin
    diff = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      diff[i] = !mirror_valid_q ||
                (win_addr[i*NIB_W +: NIB_W] != mirror_q[i*NIB_W +: NIB_W]);
    end
  end
`endif

  // Next-state logic: outputs are computed for the cycle after the edge.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    nib_cnt_d = nib_cnt_q;
    shadow_d  = shadow_q;
    pend_d    = pend_q;
    mar_d_d   = mar_d_q;
    gnt_d     = '0;
    done_d    = 1'b0;
    mar_g_d   = 1'b0;
    mar_g1_d  = 1'b1;
    mar_g2_d  = 1'b1;
    src       = shadow_q;
    mask      = pend_q;
    do_strobe = 1'b0;
    sidx      = '0;
`ifdef MAR_SKIP_UNCHANGED_EN
    mirror_d       = mirror_q;
    mirror_valid_d = mirror_valid_q;
`endif

    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          win_d    = arb_idx;
          shadow_d = win_addr;
          src      = win_addr;
`ifdef MAR_SKIP_UNCHANGED_EN
          mask     = diff;
`else
          mask     = '1;
`endif
          if (mask == '0) begin
            state_d = ACK;
            gnt_d   = arb_oh;
            done_d  = 1'b1;
`ifdef MAR_SKIP_UNCHANGED_EN
            mirror_valid_d = 1'b1;
`endif
          end else begin
            do_strobe = 1'b1;
          end
        end
      end
      LOAD: begin
        if (pend_q == '0) begin
          state_d = ACK;
          gnt_d   = NUM_REQ'(1) << win_q;
          done_d  = 1'b1;
`ifdef MAR_SKIP_UNCHANGED_EN
          mirror_valid_d = 1'b1;
`endif
        end else begin
          do_strobe = 1'b1;
        end
      end
      ACK: begin
        state_d = IDLE;
        ptr_d   = (int'(win_q) == NUM_REQ - 1) ? '0 : win_q + REQ_IDX_W'(1);
      end
      default: state_d = IDLE;
    endcase

    // Strobe the lowest pending nibble and retire it from the mask.
    if (do_strobe) begin
      sidx      = lowest_nib(MAX_NIBBLES'(mask));
      state_d   = LOAD;
      nib_cnt_d = sidx;
      mar_d_d   = src[int'(sidx)*NIB_W +: NIB_W];
      mar_g_d   = 1'b1;
      mar_g1_d  = 1'b0;
      mar_g2_d  = 1'b0;
      pend_d    = mask & ~(NIBBLES'(1) << sidx);
`ifdef MAR_SKIP_UNCHANGED_EN
      mirror_d[int'(sidx)*NIB_W +: NIB_W] = src[int'(sidx)*NIB_W +: NIB_W];
`endif
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      mar_d_q   <= '0;
      mar_g_q   <= 1'b0;
      mar_g1_q  <= 1'b1;
      mar_g2_q  <= 1'b1;
      ptr_q     <= '0;
      win_q     <= '0;
      nib_cnt_q <= '0;
      shadow_q  <= '0;
      pend_q    <= '0;
`ifdef MAR_SKIP_UNCHANGED_EN
      mirror_q       <= '0;
      mirror_valid_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      mar_d_q   <= mar_d_d;
      mar_g_q   <= mar_g_d;
      mar_g1_q  <= mar_g1_d;
      mar_g2_q  <= mar_g2_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      nib_cnt_q <= nib_cnt_d;
      shadow_q  <= shadow_d;
      pend_q    <= pend_d;
`ifdef MAR_SKIP_UNCHANGED_EN
      mirror_q       <= mirror_d;
      mirror_valid_q <= mirror_valid_d;
`endif
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;
  assign bus.mar_d   = mar_d_q;
  assign bus.mar_sel = nib_cnt_q;
  assign bus.mar_g   = mar_g_q;
  assign bus.mar_g1  = mar_g1_q;
  assign bus.mar_g2  = mar_g2_q;
endmodule

// File: tb/tb_mar_load_sequencer.sv
// tb_mar_load_sequencer: scoreboard bench for mar_load_sequencer
// (default build: NUM_REQ=3, NIBBLES=4, NIB_W=4). Stimulus pushes expected
// MAR strobes and grants into queues; a negedge monitor pops and compares.
module tb_mar_load_sequencer;
  import mar_ctrl_pkg::*;

  localparam int NUM_REQ = 3;
  localparam int NIBBLES = 4;
  localparam int NIB_W   = 4;
  localparam int AW      = NIBBLES * NIB_W;

  typedef struct {
    logic [1:0] sel;
    logic [3:0] d;
  } strobe_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mar_load_sequencer_if #(.NUM_REQ(NUM_REQ), .NIBBLES(NIBBLES), .NIB_W(NIB_W)) bus ();

  mar_load_sequencer #(.NUM_REQ(NUM_REQ), .NIBBLES(NIBBLES), .NIB_W(NIB_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int gnts_seen = 0;
  strobe_t    exp_strobe[$];
  logic [2:0] exp_gnt[$];
  int         gnt_times[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every strobe and grant against the scoreboard queues.
  always @(negedge clk) begin
    strobe_t    es;
    logic [2:0] eg;
    if (rst === 1'b0) begin
      if (bus.mar_g) begin
        if (exp_strobe.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_strobe: got sel=%0d d=0x%0h expected no strobe", bus.mar_sel, bus.mar_d);
        end else begin
          es = exp_strobe.pop_front();
          chk("strobe_sel", 32'(bus.mar_sel), 32'(es.sel));
          chk("strobe_d", 32'(bus.mar_d), 32'(es.d));
          chk("strobe_g1g2", 32'({bus.mar_g1, bus.mar_g2}), 32'd0);
        end
      end
      if (bus.gnt != '0 || bus.done) begin
        if (exp_gnt.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_gnt: got gnt=%b done=%b expected none", bus.gnt, bus.done);
        end else begin
          eg = exp_gnt.pop_front();
          chk("gnt", 32'(bus.gnt), 32'(eg));
          chk("done", 32'(bus.done), 32'd1);
          chk("gnt_strobe_off", 32'({bus.mar_g, bus.mar_g1, bus.mar_g2}), 32'b011);
          gnt_times.push_back(cyc);
          gnts_seen++;
        end
      end
    end
  end

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    bus.addr_in[i*AW +: AW] = a;
  endtask

  task automatic push_load(input logic [AW-1:0] a, input logic [2:0] g);
    strobe_t s;
    for (int i = 0; i < NIBBLES; i++) begin
      s.sel = 2'(i);
      s.d   = a[i*NIB_W +: NIB_W];
      exp_strobe.push_back(s);
    end
    exp_gnt.push_back(g);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_gnt"},     32'(bus.gnt), 32'd0);
    chk({tag, "_done"},    32'(bus.done), 32'd0);
    chk({tag, "_busy"},    32'(bus.busy), 32'd0);
    chk({tag, "_mar_g"},   32'(bus.mar_g), 32'd0);
    chk({tag, "_mar_g1"},  32'(bus.mar_g1), 32'd1);
    chk({tag, "_mar_g2"},  32'(bus.mar_g2), 32'd1);
    chk({tag, "_mar_d"},   32'(bus.mar_d), 32'd0);
    chk({tag, "_mar_sel"}, 32'(bus.mar_sel), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_gnts(input int n);
    int k = 0;
    while (gnts_seen < n && k < 300) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (gnts_seen < n) begin
      checks++; errors++;
      $display("FAIL wait_gnt: got %0d grants expected %0d", gnts_seen, n);
    end
  endtask

  initial begin
    int accept_cyc;
    int base;
    int t0;
    rst = 1'b1;
    bus.req = '0;
    bus.addr_in = '0;

    // Reset state
    @(posedge clk);
    #1 check_reset_outputs("reset");
    rst = 1'b0;

    // Single request from requester 0, address 0xA5C3
    @(posedge clk);
    #1 set_addr(0, 16'hA5C3);
    bus.req = 3'b001;
    push_load(16'hA5C3, 3'b001);
    @(posedge clk);
    #1 accept_cyc = cyc;
    bus.req = '0;
    chk("single_busy_load", 32'(bus.busy), 32'd1);
    wait_gnts(1);
    if (gnt_times.size() >= 1)
      chk("single_latency", 32'(gnt_times[0] - accept_cyc), 32'(NIBBLES));
    @(negedge clk);
    #1 chk("single_busy_after", 32'(bus.busy), 32'd0);
    chk("single_drained", 32'(exp_strobe.size()), 32'd0);

    // All three requesting continuously: order 0,1,2,0 spaced NIBBLES+2
    do_reset();
    set_addr(0, 16'h3210);
    set_addr(1, 16'h7654);
    set_addr(2, 16'hBA98);
    push_load(16'h3210, 3'b001);
    push_load(16'h7654, 3'b010);
    push_load(16'hBA98, 3'b100);
    push_load(16'h3210, 3'b001);
    base = gnts_seen;
    t0 = gnt_times.size();
    bus.req = 3'b111;
    wait_gnts(base + 4);
    bus.req = '0;
    if (gnt_times.size() >= t0 + 4) begin
      for (int k = 1; k < 4; k++)
        chk("rr_spacing", 32'(gnt_times[t0+k] - gnt_times[t0+k-1]), 32'(NIBBLES + 2));
    end

    // Request pulsed for one cycle; address changed during the load
    do_reset();
    set_addr(0, 16'h4D2E);
    bus.req = 3'b001;
    push_load(16'h4D2E, 3'b001);
    @(posedge clk);
    #1 bus.req = '0;
    set_addr(0, 16'hFFFF);
    wait_gnts(gnts_seen + 1);

    // Asynchronous reset during the second LOAD cycle
    do_reset();
    begin
      strobe_t s;
      s.sel = 2'd0;
      s.d   = 4'h7;
      exp_strobe.push_back(s);
    end
    set_addr(1, 16'h1357);
    bus.req = 3'b010;
    base = gnts_seen;
    @(posedge clk);
    #1 bus.req = '0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check_reset_outputs("midload_reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("midload_no_gnt", 32'(gnts_seen), 32'(base));
    chk("midload_drained", 32'(exp_strobe.size()), 32'd0);

    // Pointer back at 0: requester 0 beats requester 1
    set_addr(0, 16'h0F0F);
    set_addr(1, 16'h2468);
    push_load(16'h0F0F, 3'b001);
    push_load(16'h2468, 3'b010);
    bus.req = 3'b011;
    wait_gnts(base + 2);
    bus.req = '0;

    repeat (3) @(negedge clk);
    #1 chk("final_busy", 32'(bus.busy), 32'd0);
    chk("final_strobes_left", 32'(exp_strobe.size()), 32'd0);
    chk("final_gnts_left", 32'(exp_gnt.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
